// File: rtl/uart_rx_pkg.sv
// Shared state encoding and sizing constants for the UART receive framing stage.
// Consumers: uart_rx_frame_fsm (parity state used only with UART_RX_PARITY_EN).
package uart_rx_pkg;

   localparam int unsigned DEF_DATA_BITS  = 8;
   localparam int unsigned DEF_OVERSAMPLE = 4;

   // A one-value counter still needs a single bit of storage.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   localparam int unsigned TICK_CNT_W = cnt_width(DEF_OVERSAMPLE);
   localparam int unsigned BIT_CNT_W  = cnt_width(DEF_DATA_BITS);

   typedef enum logic [2:0] {
      StIdle     = 3'd0,
      StData     = 3'd1,
      StParity   = 3'd2,
      StStop     = 3'd3,
      StWaitIdle = 3'd4
   } state_e;

endpackage

// File: rtl/uart_rx_frame_fsm.sv
// UART receive framing FSM: start/data/(parity)/stop tracking on baud ticks, LSB-first assembly.
// Optional parity stage compiled in with the UART_RX_PARITY_EN macro.
module uart_rx_frame_fsm
   import uart_rx_pkg::*;
#(
   parameter int unsigned DATA_BITS  = DEF_DATA_BITS,
   parameter int unsigned OVERSAMPLE = DEF_OVERSAMPLE,
   parameter int unsigned PARITY_ODD = 0
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_baudclk,
   input  logic                 i_onedetected,
   input  logic                 i_zerodetected,
   output logic [DATA_BITS-1:0] o_data,
   output logic                 o_valid,
   output logic                 o_frame_err,
   output logic                 o_noise_err,
   output logic                 o_parity_err,
   output logic                 o_busy
);

   localparam int unsigned TICK_W = cnt_width(OVERSAMPLE);
   localparam int unsigned BIT_W  = cnt_width(DATA_BITS);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

   if (DATA_BITS < 5 || DATA_BITS > 9 || OVERSAMPLE < 1 || PARITY_ODD > 1) begin : g_bad_params
      $error("uart_rx_frame_fsm: illegal parameter combination");
   end

   state_e               r_state;
   logic [TICK_W-1:0]    r_tick;
   logic [BIT_W-1:0]     r_bit;
   logic [DATA_BITS-1:0] r_shift;
   logic [DATA_BITS-1:0] r_data;
   logic                 r_noise;
   logic                 r_valid;
   logic                 r_frame_err;
   logic                 r_noise_err;
   logic                 r_busy;
`ifdef UART_RX_PARITY_EN
   logic                 r_par;
   logic                 r_parity_err;
`endif

   logic                 w_sample;
   logic                 w_bit;
   logic                 w_noisy;
   logic [TICK_W-1:0]    w_tick_next;

   // Neither flag set means the window was mixed: treat as 0 and remember the noise.
   assign w_sample    = (r_tick == TICK_LAST);
   assign w_bit       = i_onedetected;
   assign w_noisy     = ~i_onedetected & ~i_zerodetected;
   assign w_tick_next = w_sample ? '0 : r_tick + TICK_W'(1);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= StIdle;
         r_tick      <= '0;
         r_bit       <= '0;
         r_shift     <= '0;
         r_data      <= '0;
         r_noise     <= 1'b0;
         r_valid     <= 1'b0;
         r_frame_err <= 1'b0;
         r_noise_err <= 1'b0;
         r_busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_par        <= 1'b0;
         r_parity_err <= 1'b0;
`endif
      end else begin
         r_valid <= 1'b0;
         if (i_baudclk) begin
            unique case (r_state)
               StIdle: begin
                  if (i_zerodetected) begin
                     r_state <= StData;
                     r_tick  <= '0;
                     r_bit   <= '0;
                     r_noise <= 1'b0;
                     r_busy  <= 1'b1;
`ifdef UART_RX_PARITY_EN
                     r_par   <= (PARITY_ODD != 0);
`endif
                  end
               end
               StData: begin
                  r_tick <= w_tick_next;
                  if (w_sample) begin
                     r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
                     r_noise <= r_noise | w_noisy;
`ifdef UART_RX_PARITY_EN
                     r_par   <= r_par ^ w_bit;
`endif
                     if (r_bit == BIT_LAST) begin
                        r_bit   <= '0;
`ifdef UART_RX_PARITY_EN
                        r_state <= StParity;
`else
                        r_state <= StStop;
`endif
                     end else begin
                        r_bit <= r_bit + BIT_W'(1);
                     end
                  end
               end
`ifdef UART_RX_PARITY_EN
               StParity: begin
                  r_tick <= w_tick_next;
                  if (w_sample) begin
                     r_par   <= r_par ^ w_bit;
                     r_noise <= r_noise | w_noisy;
                     r_state <= StStop;
                  end
               end
`endif
               StStop: begin
                  r_tick <= w_tick_next;
                  if (w_sample) begin
                     r_data      <= r_shift;
                     r_frame_err <= ~w_bit;
                     r_noise_err <= r_noise | w_noisy;
`ifdef UART_RX_PARITY_EN
                     r_parity_err <= r_par;
`endif
                     r_valid     <= 1'b1;
                     // A low stop bit may be a break; wait for the line to go high again.
                     r_busy      <= ~w_bit;
                     r_state     <= w_bit ? StIdle : StWaitIdle;
                  end
               end
               StWaitIdle: begin
                  if (i_onedetected) begin
                     r_state <= StIdle;
                     r_busy  <= 1'b0;
                  end
               end
               default: begin
                  r_state <= StIdle;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign o_data      = r_data;
   assign o_valid     = r_valid;
   assign o_frame_err = r_frame_err;
   assign o_noise_err = r_noise_err;
   assign o_busy      = r_busy;
`ifdef UART_RX_PARITY_EN
   assign o_parity_err = r_parity_err;
`else
   assign o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_frame_fsm.sv
// Bench for uart_rx_frame_fsm: drives checker flags tick by tick and compares each frame
// against a word-level model; honours UART_RX_PARITY_EN when defined.
`timescale 1ns/1ps
module tb_uart_rx_frame_fsm;

   localparam int unsigned DB   = 8;
   localparam int unsigned OS   = 4;
   localparam int unsigned PODD = 0;

   typedef struct packed {
      logic [DB-1:0] data;
      logic          fe;
      logic          ne;
      logic          pe;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          baud;
   logic          one;
   logic          zero;
   logic [DB-1:0] o_data;
   logic          o_valid;
   logic          o_frame_err;
   logic          o_noise_err;
   logic          o_parity_err;
   logic          o_busy;

   int n_vec       = 0;
   int n_err       = 0;
   int n_pulse     = 0;
   int n_exp_pulse = 0;

   uart_rx_frame_fsm #(
      .DATA_BITS  (DB),
      .OVERSAMPLE (OS),
      .PARITY_ODD (PODD)
   ) dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_baudclk      (baud),
      .i_onedetected  (one),
      .i_zerodetected (zero),
      .o_data         (o_data),
      .o_valid        (o_valid),
      .o_frame_err    (o_frame_err),
      .o_noise_err    (o_noise_err),
      .o_parity_err   (o_parity_err),
      .o_busy         (o_busy)
   );

   always #5 clk = ~clk;

   // Counts completed valid cycles (value seen here is the one from the previous cycle).
   always @(posedge clk) if (o_valid === 1'b1) n_pulse++;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "watchdog");
   end

   // Expected frame result from the line-level rules.
   function automatic exp_t model(input logic [DB-1:0] word, input logic stop_bit,
                                  input int noisy, input logic par_bit);
      exp_t e;
      int   ones;
      e.data = word;
      if (noisy >= 0 && noisy < DB) e.data[noisy] = 1'b0;
      e.fe = ~stop_bit;
      e.ne = (noisy >= 0);
`ifdef UART_RX_PARITY_EN
      ones = $countones(e.data) + ((noisy == DB) ? 0 : int'(par_bit)) + PODD;
      e.pe = ones[0];
`else
      ones = int'(par_bit) & 0;
      e.pe = ones[0];
`endif
      return e;
   endfunction

   function automatic logic good_par(input logic [DB-1:0] word);
      logic p;
      p = ^word;
      return (PODD != 0) ? ~p : p;
   endfunction

   task automatic tick(input logic f_one, input logic f_zero);
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
         baud = 1'b0;
         one  = 1'($urandom);
         zero = 1'($urandom);
         @(negedge clk);
      end
      baud = 1'b1;
      one  = f_one;
      zero = f_zero;
      @(negedge clk);
      baud = 1'b0;
   endtask

   // One bit period: only the last tick is a sample point, earlier ticks carry junk flags.
   task automatic send_bit(input logic b, input logic noisy);
      for (int t = 0; t < int'(OS) - 1; t++) tick(1'($urandom), 1'($urandom));
      if (noisy) tick(1'b0, 1'b0);
      else       tick(b, ~b);
   endtask

   task automatic send_frame(input logic [DB-1:0] word, input logic stop_bit, input int noisy,
                             input logic par_bit, input int idle_ticks);
      for (int i = 0; i < idle_ticks; i++) tick(1'b1, 1'b0);
      tick(1'b0, 1'b1);
      for (int i = 0; i < int'(DB); i++) send_bit(word[i], i == noisy);
`ifdef UART_RX_PARITY_EN
      send_bit(par_bit, noisy == int'(DB));
`else
      if (par_bit === 1'bx) $display("par_bit unknown");
`endif
      send_bit(stop_bit, 1'b0);
      n_exp_pulse++;
   endtask

   task automatic test_reset();
      rst = 1'b1; baud = 1'b1; one = 1'b0; zero = 1'b1;
      repeat (3) @(negedge clk);
      n_vec++;
      if ({o_valid, o_busy, o_frame_err, o_noise_err, o_parity_err, o_data} !== '0) begin
         n_err++;
         $display("FAIL reset_in: got v=%b busy=%b fe=%b ne=%b pe=%b data=%h, want all 0",
                  o_valid, o_busy, o_frame_err, o_noise_err, o_parity_err, o_data);
      end
      rst = 1'b0; baud = 1'b0; one = 1'b1; zero = 1'b0;
      repeat (4) tick(1'b1, 1'b0);
      n_vec++;
      if ({o_valid, o_busy} !== 2'b00) begin
         n_err++;
         $display("FAIL reset_idle: got v=%b busy=%b, want 0 0", o_valid, o_busy);
      end
   endtask

   task automatic test_basic();
      exp_t e;
      e = model(8'hA5, 1'b1, -1, good_par(8'hA5));
      send_frame(8'hA5, 1'b1, -1, good_par(8'hA5), 3);
      n_vec++;
      if ({o_valid, o_data, o_frame_err, o_noise_err, o_parity_err} !== {1'b1, e}) begin
         n_err++;
         $display("FAIL basic_a5: got v=%b data=%h fe=%b ne=%b pe=%b, want v=1 data=%h fe=%b ne=%b pe=%b",
                  o_valid, o_data, o_frame_err, o_noise_err, o_parity_err, e.data, e.fe, e.ne, e.pe);
      end
      n_vec++;
      if (o_busy !== 1'b0) begin
         n_err++;
         $display("FAIL basic_busy: got busy=%b, want 0", o_busy);
      end
      @(negedge clk);
      n_vec++;
      if (o_valid !== 1'b0 || o_data !== 8'hA5) begin
         n_err++;
         $display("FAIL basic_pulse: got v=%b data=%h one cycle later, want v=0 data=a5", o_valid, o_data);
      end
   endtask

   task automatic test_frame_err();
      exp_t e;
      int   p0;
      e = model(8'h3C, 1'b0, -1, good_par(8'h3C));
      send_frame(8'h3C, 1'b0, -1, good_par(8'h3C), 2);
      n_vec++;
      if ({o_valid, o_data, o_frame_err, o_noise_err, o_parity_err} !== {1'b1, e}) begin
         n_err++;
         $display("FAIL ferr_3c: got v=%b data=%h fe=%b ne=%b pe=%b, want v=1 data=%h fe=%b ne=%b pe=%b",
                  o_valid, o_data, o_frame_err, o_noise_err, o_parity_err, e.data, e.fe, e.ne, e.pe);
      end
      @(negedge clk);
      p0 = n_pulse;
      for (int i = 0; i < 2 * (int'(DB) + 3) * int'(OS); i++) tick(1'b0, 1'b1);
      @(negedge clk);
      n_vec++;
      if (n_pulse !== p0 || o_busy !== 1'b1) begin
         n_err++;
         $display("FAIL ferr_hold: got pulses=%0d busy=%b while line low, want pulses=%0d busy=1",
                  n_pulse, o_busy, p0);
      end
      e = model(8'h55, 1'b1, -1, good_par(8'h55));
      send_frame(8'h55, 1'b1, -1, good_par(8'h55), 2);
      n_vec++;
      if ({o_valid, o_data, o_frame_err, o_noise_err, o_parity_err} !== {1'b1, e}) begin
         n_err++;
         $display("FAIL ferr_55: got v=%b data=%h fe=%b ne=%b pe=%b, want v=1 data=%h fe=%b ne=%b pe=%b",
                  o_valid, o_data, o_frame_err, o_noise_err, o_parity_err, e.data, e.fe, e.ne, e.pe);
      end
   endtask

   task automatic test_noise();
      exp_t e;
      e = model(8'hFF, 1'b1, 2, good_par(8'hFB));
      send_frame(8'hFF, 1'b1, 2, good_par(8'hFB), 2);
      n_vec++;
      if ({o_valid, o_data, o_frame_err, o_noise_err, o_parity_err} !== {1'b1, e} || e.data !== 8'hFB) begin
         n_err++;
         $display("FAIL noise_bit2: got v=%b data=%h fe=%b ne=%b pe=%b, want v=1 data=%h fe=%b ne=%b pe=%b",
                  o_valid, o_data, o_frame_err, o_noise_err, o_parity_err, e.data, e.fe, e.ne, e.pe);
      end
   endtask

   task automatic test_parity();
      exp_t e;
      for (int k = 0; k < 2; k++) begin
         e = model(8'h07, 1'b1, -1, (k == 0));
         send_frame(8'h07, 1'b1, -1, (k == 0), 2);
         n_vec++;
         if ({o_valid, o_data, o_frame_err, o_noise_err, o_parity_err} !== {1'b1, e}) begin
            n_err++;
            $display("FAIL parity_07[%0d]: got v=%b data=%h fe=%b ne=%b pe=%b, want v=1 data=%h fe=%b ne=%b pe=%b",
                     k, o_valid, o_data, o_frame_err, o_noise_err, o_parity_err, e.data, e.fe, e.ne, e.pe);
         end
      end
   endtask

   task automatic test_reset_mid();
      exp_t e;
      int   p0;
      logic [DB-1:0] w;
      w = 8'h81;
      for (int i = 0; i < 2; i++) tick(1'b1, 1'b0);
      tick(1'b0, 1'b1);
      for (int i = 0; i < 5; i++) send_bit(w[i], 1'b0);
      p0 = n_pulse;
      #2 rst = 1'b1;
      #1;
      n_vec++;
      if ({o_valid, o_busy, o_frame_err, o_noise_err, o_parity_err, o_data} !== '0) begin
         n_err++;
         $display("FAIL rst_mid: got v=%b busy=%b fe=%b ne=%b pe=%b data=%h, want all 0",
                  o_valid, o_busy, o_frame_err, o_noise_err, o_parity_err, o_data);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) tick(1'b1, 1'b0);
      @(negedge clk);
      n_vec++;
      if (n_pulse !== p0 || o_busy !== 1'b0) begin
         n_err++;
         $display("FAIL rst_mid_quiet: got pulses=%0d busy=%b, want pulses=%0d busy=0", n_pulse, o_busy, p0);
      end
      e = model(w, 1'b1, -1, good_par(w));
      send_frame(w, 1'b1, -1, good_par(w), 2);
      n_vec++;
      if ({o_valid, o_data, o_frame_err, o_noise_err, o_parity_err} !== {1'b1, e}) begin
         n_err++;
         $display("FAIL rst_mid_81: got v=%b data=%h fe=%b ne=%b pe=%b, want v=1 data=%h fe=%b ne=%b pe=%b",
                  o_valid, o_data, o_frame_err, o_noise_err, o_parity_err, e.data, e.fe, e.ne, e.pe);
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      logic [DB-1:0] w;
      for (int k = 0; k < 2; k++) begin
         w = (k == 0) ? 8'h00 : 8'hFF;
         e = model(w, 1'b1, -1, good_par(w));
         send_frame(w, 1'b1, -1, good_par(w), (k == 0) ? 2 : 0);
         n_vec++;
         if ({o_valid, o_data, o_frame_err, o_noise_err, o_parity_err} !== {1'b1, e}) begin
            n_err++;
            $display("FAIL b2b[%0d]: got v=%b data=%h fe=%b ne=%b pe=%b, want v=1 data=%h fe=%b ne=%b pe=%b",
                     k, o_valid, o_data, o_frame_err, o_noise_err, o_parity_err, e.data, e.fe, e.ne, e.pe);
         end
      end
   endtask

   task automatic test_random();
      exp_t          e;
      logic [DB-1:0] w;
      logic          stop_bit;
      logic          par;
      logic          prev_stop;
      int            noisy;
      int            idle;
`ifdef UART_RX_PARITY_EN
      int            nmax = int'(DB);
`else
      int            nmax = int'(DB) - 1;
`endif
      prev_stop = 1'b1;
      for (int n = 0; n < 40; n++) begin
         w        = DB'($urandom);
         stop_bit = ($urandom_range(0, 4) != 0);
         par      = 1'($urandom);
         noisy    = ($urandom_range(0, 3) == 0) ? $urandom_range(0, nmax) : -1;
         idle     = prev_stop ? $urandom_range(0, 3) : $urandom_range(1, 3);
         e = model(w, stop_bit, noisy, par);
         send_frame(w, stop_bit, noisy, par, idle);
         n_vec++;
         if ({o_valid, o_data, o_frame_err, o_noise_err, o_parity_err} !== {1'b1, e}) begin
            n_err++;
            $display("FAIL rand[%0d]: got v=%b data=%h fe=%b ne=%b pe=%b, want v=1 data=%h fe=%b ne=%b pe=%b",
                     n, o_valid, o_data, o_frame_err, o_noise_err, o_parity_err, e.data, e.fe, e.ne, e.pe);
         end
         prev_stop = stop_bit;
      end
   endtask

   initial begin
      rst = 1'b1; baud = 1'b0; one = 1'b1; zero = 1'b0;
      test_reset();
      test_basic();
      test_frame_err();
      test_noise();
      test_parity();
      test_reset_mid();
      test_back_to_back();
      test_random();
      repeat (4) @(negedge clk);
      n_vec++;
      if (n_pulse !== n_exp_pulse) begin
         n_err++;
         $display("FAIL pulse_count: got %0d valid pulses, want %0d", n_pulse, n_exp_pulse);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/uart_rx_frame_fsm.md
Name: uart_rx_frame_fsm

Overview:
- Receive-side framing stage that sits directly downstream of the receiver's majority bit checker.
- Consumes the checker's registered one/zero detect flags on baud-tick cycles and tracks the start, data, optional parity and stop bits.
- Assembles the data word LSB first and presents it with a one-cycle valid pulse plus error qualifiers to the receive buffer/host side.

Parameters:
- DATA_BITS, 8: data bits per frame, legal range 5..9.
- OVERSAMPLE, 4: baud ticks per bit period; equals the checker's sample depth.
- PARITY_ODD, 0: 0 selects even parity, 1 selects odd. Used only when UART_RX_PARITY_EN is defined.

Ports:
- i_clk  input  1  system clock.
- i_rst  input  1  asynchronous, active-high reset.
- i_baudclk  input  1  oversample tick, a one-i_clk-cycle enable pulse; the same tick that drives the checker.
- i_onedetected  input  1  checker flag: the last OVERSAMPLE samples were all 1.
- i_zerodetected  input  1  checker flag: the last OVERSAMPLE samples were all 0.
- o_data  output  DATA_BITS  received word; holds its value until the next frame completes.
- o_valid  output  1  one-cycle pulse at frame end.
- o_frame_err  output  1  stop bit not seen as 1; qualified by o_valid.
- o_noise_err  output  1  some sample point had neither flag set; qualified by o_valid.
- o_parity_err  output  1  parity mismatch; qualified by o_valid; constant 0 when the feature is compiled out.
- o_busy  output  1  high in every state except IDLE.

Behaviour:
- One clock. Reset is asynchronous and active-high on i_rst. Every state change and all sampling happen on posedge i_clk and only in cycles where i_baudclk=1; other cycles hold all state.
- Reset values: state=IDLE, tick_cnt=0, bit_cnt=0, o_data=0, o_valid=0, o_frame_err=0, o_noise_err=0, o_parity_err=0, o_busy=0.
- States: IDLE, DATA, PARITY, STOP, WAIT_IDLE.
- IDLE, on tick with i_zerodetected=1: go to DATA; clear tick_cnt, bit_cnt and the sticky noise flag. A full zero window is the start bit.
- Sample point: tick_cnt counts ticks inside a state and wraps at OVERSAMPLE-1. The sample is taken on the tick where tick_cnt==OVERSAMPLE-1, i.e. the OVERSAMPLE-th tick after entering the bit.
- Bit value at a sample point: i_onedetected gives 1; else i_zerodetected gives 0; else the bit is 0 and the sticky noise flag is set. If both flags are 1 (illegal), one wins and noise is not set.
- DATA: the sampled bit shifts into the MSB of the shift register (LSB first on the line). After the DATA_BITS-th bit, go to PARITY if the feature is enabled, else to STOP.
- STOP, at its sample point:
  - o_data <= shift register.
  - o_frame_err <= ~bit.
  - o_noise_err <= noise flag.
  - o_parity_err <= parity result.
  - o_valid pulses on the next i_clk edge, for exactly 1 cycle.
  - Next state: IDLE if the stop bit was 1; WAIT_IDLE if it was 0 (break or framing slip).
- Latency: o_valid is high for the single i_clk cycle following the stop-bit sample tick. Error flags are meaningful only while o_valid=1.
- WAIT_IDLE: return to IDLE on the first tick with i_onedetected=1. This prevents a held-low line from re-triggering endless frames.
- Flags are ignored on non-tick cycles. A tick arriving on the cycle o_valid is high is processed normally.
- i_rst asserted mid-frame aborts immediately to the reset values. No partial frame and no o_valid is produced.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined: PARITY state of one bit period follows DATA. parity_calc = XOR(data bits, received parity bit) XOR PARITY_ODD. o_parity_err = parity_calc != 0, reported at STOP with o_valid. A noisy parity sample also sets the noise flag.
- Undefined: no PARITY state; DATA goes directly to STOP; o_parity_err is tied to 0.

Decomposition:
- Package uart_rx_pkg holds: the state encoding (IDLE, DATA, PARITY, STOP, WAIT_IDLE), the default DATA_BITS and OVERSAMPLE constants, and the tick/bit counter width constants, sized by clog2.
- Single module. No sub-module is needed; the counter, shift register and FSM stay together.

Test Plan:
- Defaults, no parity: idle line held 1, then start plus 0xA5 LSB first plus stop 1 -> o_data=0xA5, single o_valid pulse, all error flags 0, o_busy low afterward.
- Stop bit driven 0 with data 0x3C -> o_valid with o_frame_err=1, o_data=0x3C. FSM stays in WAIT_IDLE while the line is 0 and accepts a following 0x55 frame only after the line returns to 1.
- Data bit 2 of 0xFF with flags forced 0/0 at its sample point -> o_data=0xFB, o_noise_err=1, o_frame_err=0.
- UART_RX_PARITY_EN, PARITY_ODD=0: 0x07 with parity bit 1 -> o_parity_err=0; same word with parity bit 0 -> o_parity_err=1.
- i_rst pulsed after data bit 4 of a 0x81 frame -> no o_valid, all outputs 0. A subsequent 0x81 frame is received cleanly.
- Back-to-back frames 0x00 then 0xFF, with the new start window beginning immediately after stop -> two o_valid pulses, data 0x00 then 0xFF, no errors.
